// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch front end.
//   PC_W / INSTR_W : PC and instruction widths
//   AW             : instruction memory word-address width
//   fetch_pkt_t    : one buffered fetch result {instr, pc}
//   jal_target()   : PC-relative target of a JAL word, truncated to PC_W
package core_pkg;

  localparam int unsigned PC_W    = 9;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned AW      = PC_W - 2;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [AW-1:0]      waddr_t;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } fetch_pkt_t;

  // J-type immediate is {imm[20], imm[10:1], imm[11], imm[19:12]} in instr[31:12].
  function automatic pc_t jal_target(input pc_t pc, input instr_t instr);
    logic [20:0] imm;
    imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    return pc + imm[PC_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: backend redirect, instruction memory port and the
// fetch->decode valid/ready handshake.
//   master : the fetch unit side
//   slave  : the environment side (backend, imem, decoder)
interface fetch_unit_if;
  import core_pkg::*;

  logic   i_redirect;
  pc_t    i_redirect_pc;
  logic   o_imem_en;
  waddr_t o_imem_addr;
  instr_t i_imem_rdata;
  instr_t o_instruction;
  pc_t    o_pc;
  logic   o_valid;
  logic   i_ready;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
    output o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
    input  o_imem_en, o_imem_addr, o_instruction, o_pc, o_valid
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch_pkt_t.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_pkt at the tail
//   pop       : drop the head entry
//   flush     : empty the FIFO (wins over push/pop)
//   head      : registered head entry
//   count     : occupancy 0..2
module fetch_buffer
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output fetch_pkt_t head,
  output logic [1:0] count
);

  fetch_pkt_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      // Storage is left as is; consumers only look at it while count != 0.
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_pkt;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end, producer side of fetch->decode.
// Sequences the PC, issues reads to a 1-cycle-latency synchronous imem, buffers
// returned words in a 2-entry queue and presents the queue head to decode.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch_unit_if.master (redirect, imem port, decode handshake)
// Build option: FETCH_JAL_PREDICT_EN enables redirecting fetch to the target
// of a returning JAL word (otherwise fetch is purely sequential).
module fetch_unit
  import core_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  pc_t        pc_q, pc_d;
  logic       inflight_q;
  pc_t        inflight_pc_q;
  logic [1:0] count;
  fetch_pkt_t head;
  logic       deq;
  logic       ret;
  logic       issue;
  pc_t        issue_pc;
  logic [2:0] credit_used;

  // Queue state is EMPTY (0), PARTIAL (1) or FULL (2); valid is purely registered.
  assign bus.o_valid       = (count != 2'd0);
  assign bus.o_instruction = head.instr;
  assign bus.o_pc          = head.pc;

  assign deq = bus.o_valid & bus.i_ready;

  // Data returns the cycle after issue, so a redirect in the return cycle is
  // exactly what kills the in-flight read.
  assign ret = inflight_q & ~bus.i_redirect;

  // Slots that will be committed after this edge: buffered + returning - leaving.
  assign credit_used = {1'b0, count} + {2'b0, inflight_q} - {2'b0, deq};

  always_comb begin
    issue    = 1'b0;
    issue_pc = pc_q;
    pc_d     = pc_q;
    if (reset) begin
      issue = 1'b0;
    end else if (bus.i_redirect) begin
      issue    = 1'b1;
      issue_pc = {bus.i_redirect_pc[PC_W-1:2], 2'b00};
      pc_d     = issue_pc + pc_t'(4);
    end else begin
      issue = (credit_used < 3'd2);
`ifdef FETCH_JAL_PREDICT_EN
      // The returning JAL is the only read in flight, so replacing this
      // cycle's issue address keeps wrong-path words out of the queue.
      if (ret && (bus.i_imem_rdata[6:0] == OPCODE_JAL)) begin
        issue_pc = jal_target(inflight_pc_q, bus.i_imem_rdata);
      end
`endif
      pc_d = issue ? (issue_pc + pc_t'(4)) : issue_pc;
    end
  end

  assign bus.o_imem_en   = issue;
  assign bus.o_imem_addr = issue_pc[PC_W-1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= issue_pc;
      end
    end
  end

  fetch_buffer u_buffer (
    .clk      (clk),
    .rst      (reset),
    .push     (ret),
    .push_pkt ('{instr: bus.i_imem_rdata, pc: inflight_pc_q}),
    .pop      (deq),
    .flush    (bus.i_redirect),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table for the start-up
// and stall sequence, hand-written redirect / wrap / JAL / reset sequences,
// and a randomized run checked against a program-order reference model.
module tb_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instr_t mem [2**AW];

  // Synchronous imem model: data the cycle after the enable.
  always @(posedge clk) begin
    if (bus.o_imem_en) bus.i_imem_rdata <= mem[bus.o_imem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: next PC in program order after p.
  function automatic pc_t model_next(input pc_t p);
    instr_t w;
    int     imm;
    w = mem[p[PC_W-1:2]];
`ifdef FETCH_JAL_PREDICT_EN
    if (w[6:0] == 7'h6F) begin
      imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
      return pc_t'(int'(p) + imm);
    end
`endif
    imm = 4;
    return pc_t'(int'(p) + imm);
  endfunction

  // Wait (bounded) for the next transfer; returns its pc and instruction.
  task automatic next_xfer(output pc_t pc_o, output instr_t ins_o, output bit ok);
    ok    = 1'b0;
    pc_o  = '0;
    ins_o = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.o_valid && bus.i_ready) begin
        pc_o  = bus.o_pc;
        ins_o = bus.o_instruction;
        ok    = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic expect_xfer(input string name, input pc_t exp_pc);
    pc_t    p;
    instr_t ins;
    bit     ok;
    next_xfer(p, ins, ok);
    if (!ok) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_pc"}, 32'(p), 32'(exp_pc));
      check({name, "_instr"}, ins, mem[exp_pc[PC_W-1:2]]);
    end
  endtask

  typedef struct packed {
    bit     ready;
    bit     exp_valid;
    pc_t    exp_pc;
    bit     exp_en;
    waddr_t exp_addr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pc_t    exp_pc;
    pc_t    held_pc;
    instr_t held_ins;
    bit     have_exp;
    bit     hold_chk;
    int     xfers;

    // cycle after reset release: ready, valid, pc, imem_en, imem_addr
    vecs[0]  = '{1'b1, 1'b0, 9'h000, 1'b1, 7'h00};
    vecs[1]  = '{1'b1, 1'b0, 9'h000, 1'b1, 7'h01};
    vecs[2]  = '{1'b1, 1'b1, 9'h000, 1'b1, 7'h02};
    vecs[3]  = '{1'b1, 1'b1, 9'h004, 1'b1, 7'h03};
    vecs[4]  = '{1'b1, 1'b1, 9'h008, 1'b1, 7'h04};
    vecs[5]  = '{1'b1, 1'b1, 9'h00C, 1'b1, 7'h05};
    vecs[6]  = '{1'b0, 1'b1, 9'h010, 1'b0, 7'h00};
    vecs[7]  = '{1'b0, 1'b1, 9'h010, 1'b0, 7'h00};
    vecs[8]  = '{1'b0, 1'b1, 9'h010, 1'b0, 7'h00};
    vecs[9]  = '{1'b0, 1'b1, 9'h010, 1'b0, 7'h00};
    vecs[10] = '{1'b0, 1'b1, 9'h010, 1'b0, 7'h00};
    vecs[11] = '{1'b1, 1'b1, 9'h010, 1'b1, 7'h06};
    vecs[12] = '{1'b1, 1'b1, 9'h014, 1'b1, 7'h07};
    vecs[13] = '{1'b1, 1'b1, 9'h018, 1'b1, 7'h08};

    for (int k = 0; k < 2**AW; k++) mem[k] = instr_t'(k);

    reset             = 1'b1;
    bus.i_ready       = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_en", 32'(bus.o_imem_en), 32'd0);
    check("rst_pc", 32'(bus.o_pc), 32'd0);
    check("rst_instr", bus.o_instruction, 32'd0);
    tick();
    reset = 1'b0;

    // Start-up, stall of 5 cycles, resume.
    for (int i = 0; i < 14; i++) begin
      bus.i_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_pc", i), 32'(bus.o_pc), 32'(vecs[i].exp_pc));
        check($sformatf("vec%0d_instr", i), bus.o_instruction,
              32'(vecs[i].exp_pc[PC_W-1:2]));
      end
      check($sformatf("vec%0d_en", i), 32'(bus.o_imem_en), 32'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        check($sformatf("vec%0d_addr", i), 32'(bus.o_imem_addr), 32'(vecs[i].exp_addr));
      end
      tick();
    end

    // Fill the queue, then redirect to 0x041 while full.
    bus.i_ready = 1'b0;
    @(negedge clk);
    check("fill_en", 32'(bus.o_imem_en), 32'd0);
    tick();
    @(negedge clk);
    check("full_valid", 32'(bus.o_valid), 32'd1);
    check("full_pc", 32'(bus.o_pc), 32'h01C);
    check("full_en", 32'(bus.o_imem_en), 32'd0);
    tick();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 9'h041;
    @(negedge clk);
    check("redir_en", 32'(bus.o_imem_en), 32'd1);
    check("redir_addr", 32'(bus.o_imem_addr), 32'h10);
    tick();
    bus.i_redirect = 1'b0;
    bus.i_ready    = 1'b1;
    @(negedge clk);
    check("redir_gap_valid", 32'(bus.o_valid), 32'd0);
    tick();
    @(negedge clk);
    check("redir_tgt_valid", 32'(bus.o_valid), 32'd1);
    check("redir_tgt_pc", 32'(bus.o_pc), 32'h040);
    check("redir_tgt_instr", bus.o_instruction, 32'h10);
    tick();
    expect_xfer("redir_seq1", 9'h044);

    // Wrap-around.
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 9'h1F8;
    tick();
    bus.i_redirect = 1'b0;
    expect_xfer("wrap0", 9'h1F8);
    expect_xfer("wrap1", 9'h1FC);
    expect_xfer("wrap2", 9'h000);
    expect_xfer("wrap3", 9'h004);

    // JAL at 0x010 with immediate +0x20.
    mem[4]            = 32'h0200_006F;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 9'h000;
    tick();
    bus.i_redirect = 1'b0;
    expect_xfer("jal0", 9'h000);
    expect_xfer("jal1", 9'h004);
    expect_xfer("jal2", 9'h008);
    expect_xfer("jal3", 9'h00C);
    expect_xfer("jal4", 9'h010);
`ifdef FETCH_JAL_PREDICT_EN
    expect_xfer("jal_next", 9'h030);
`else
    expect_xfer("jal_next", 9'h014);
`endif
    mem[4] = 32'd4;

    // Asynchronous reset mid-stream.
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.o_valid), 32'd0);
    check("midrst_en", 32'(bus.o_imem_en), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("restart_en", 32'(bus.o_imem_en), 32'd1);
    check("restart_addr", 32'(bus.o_imem_addr), 32'd0);
    check("restart_valid0", 32'(bus.o_valid), 32'd0);
    tick();
    @(negedge clk);
    check("restart_valid1", 32'(bus.o_valid), 32'd0);
    tick();
    @(negedge clk);
    check("restart_valid2", 32'(bus.o_valid), 32'd1);
    check("restart_pc", 32'(bus.o_pc), 32'd0);
    tick();

    // Randomized ready/redirect against the program-order model.
    have_exp = 1'b0;
    hold_chk = 1'b0;
    exp_pc   = '0;
    held_pc  = '0;
    held_ins = '0;
    xfers    = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bus.i_ready       = ($urandom_range(3) != 0);
      bus.i_redirect    = (cyc == 0) || ($urandom_range(31) == 0);
      bus.i_redirect_pc = pc_t'($urandom);
      @(negedge clk);
      if (hold_chk) begin
        check("hold_valid", 32'(bus.o_valid), 32'd1);
        check("hold_pc", 32'(bus.o_pc), 32'(held_pc));
        check("hold_instr", bus.o_instruction, held_ins);
      end
      if (bus.o_valid && bus.i_ready && have_exp) begin
        check("rand_pc", 32'(bus.o_pc), 32'(exp_pc));
        check("rand_instr", bus.o_instruction, mem[exp_pc[PC_W-1:2]]);
        exp_pc = model_next(exp_pc);
        xfers++;
      end
      if (bus.i_redirect) begin
        exp_pc   = {bus.i_redirect_pc[PC_W-1:2], 2'b00};
        have_exp = 1'b1;
      end
      hold_chk = bus.o_valid && !bus.i_ready && !bus.i_redirect;
      held_pc  = bus.o_pc;
      held_ins = bus.o_instruction;
      tick();
    end
    check("rand_progress", 32'(xfers >= 3000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
